// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: ports A (CPU) and B (DMA/debug) share one
// data memory. Each access is IDLE -> SERVE -> DONE. Ties go round-robin by
// default. Define DMEM_ARB_FIXED_PRI_EN to give port A fixed priority on ties.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch the winner's fields
// SERVE | drive the memory from the latched fields, capture read data
// DONE  | pulse ack (and err) to the granted port

module dmem_arbiter #(
    parameter int ADDR_LIMIT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] b_addr,
    input  logic [31:0] a_wdata,
    input  logic [31:0] b_wdata,
    input  logic        a_as_byte,
    input  logic        b_as_byte,
    input  logic        a_as_unsigned,
    input  logic        b_as_unsigned,
    output logic        a_ack,
    output logic        b_ack,
    output logic        a_err,
    output logic        b_err,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic        mem_write_en,
    output logic [31:0] mem_read_addr,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_as_byte,
    output logic        mem_as_unsigned,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

    localparam logic [31:0] BYTE_LIMIT = 32'(ADDR_LIMIT);
    localparam logic [31:0] WORD_LIMIT = 32'(ADDR_LIMIT - 4);

    state_t      state;
    state_t      state_next;

    logic        pick_b;
    logic        any_req;
    logic        sel_we;
    logic        sel_byte;
    logic        sel_uns;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        range_err;

    logic        grant_b;
    logic        lat_we;
    logic        lat_byte;
    logic        lat_uns;
    logic        lat_err;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    assign any_req = a_req || b_req;

`ifdef DMEM_ARB_FIXED_PRI_EN
    // Fixed priority: B wins only when A is not requesting.
    always_comb begin
        pick_b = b_req && !a_req;
    end
`else
    // Set when B received the most recent grant; reset to B so A wins the first tie.
    logic last_b;

    // Round-robin: on a tie the port not granted last wins.
    always_comb begin
        pick_b = b_req && (!a_req || !last_b);
    end

    // Last-grant pointer moves only when a grant is actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_b <= pick_b;
        end
    end
`endif

    // Mux the winning port's request fields and range-check them before latching.
    always_comb begin
        sel_we    = pick_b ? b_we          : a_we;
        sel_byte  = pick_b ? b_as_byte     : a_as_byte;
        sel_uns   = pick_b ? b_as_unsigned : a_as_unsigned;
        sel_addr  = pick_b ? b_addr        : a_addr;
        sel_wdata = pick_b ? b_wdata       : a_wdata;
        range_err = sel_byte ? (sel_addr >= BYTE_LIMIT) : (sel_addr > WORD_LIMIT);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; memory outputs are quiet outside SERVE.
    always_comb begin
        state_next      = state;
        a_ack           = 1'b0;
        b_ack           = 1'b0;
        a_err           = 1'b0;
        b_err           = 1'b0;
        mem_write_en    = 1'b0;
        mem_read_addr   = '0;
        mem_write_addr  = '0;
        mem_write_data  = '0;
        mem_as_byte     = 1'b0;
        mem_as_unsigned = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = SERVE;
            end
            SERVE: begin
                state_next      = DONE;
                mem_write_en    = lat_we && !lat_err;
                mem_read_addr   = lat_addr;
                mem_write_addr  = lat_addr;
                mem_write_data  = lat_wdata;
                mem_as_byte     = lat_byte;
                mem_as_unsigned = lat_uns;
            end
            DONE: begin
                state_next = IDLE;
                a_ack      = !grant_b;
                b_ack      = grant_b;
                a_err      = !grant_b && lat_err;
                b_err      = grant_b && lat_err;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted request in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_b   <= 1'b0;
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_uns   <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            grant_b   <= pick_b;
            lat_we    <= sel_we;
            lat_byte  <= sel_byte;
            lat_uns   <= sel_uns;
            lat_err   <= range_err;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
        end
    end

    // Capture read data for the granted port at the end of SERVE; out-of-range reads return 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else if (state == SERVE) begin
            if (grant_b) begin
                b_rdata <= lat_err ? 32'd0 : mem_read_data;
            end else begin
                a_rdata <= lat_err ? 32'd0 : mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a little-endian byte memory model.
// Expected acks are queued when a request is driven and checked as acks appear.
// Build with DMEM_ARB_FIXED_PRI_EN defined to check the fixed-priority variant.

module tb_dmem_arbiter;

    localparam int LIM = 32;

    logic        clk;
    logic        rst_n;
    logic        a_req, b_req, a_we, b_we;
    logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
    logic        a_as_byte, b_as_byte, a_as_unsigned, b_as_unsigned;
    logic        a_ack, b_ack, a_err, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        mem_write_en;
    logic [31:0] mem_read_addr, mem_write_addr, mem_write_data;
    logic        mem_as_byte, mem_as_unsigned;
    logic [31:0] mem_read_data;

    typedef struct packed {
        logic        port;
        logic        we;
        logic        err;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic        wr_ok;
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  mem_arr [LIM];
    logic [4:0]  ra;
    logic [4:0]  wa;
    logic [7:0]  rb;

    dmem_arbiter #(.ADDR_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_as_byte(a_as_byte), .b_as_byte(b_as_byte),
        .a_as_unsigned(a_as_unsigned), .b_as_unsigned(b_as_unsigned),
        .a_ack(a_ack), .b_ack(b_ack), .a_err(a_err), .b_err(b_err),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_write_en(mem_write_en), .mem_read_addr(mem_read_addr),
        .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_as_byte(mem_as_byte), .mem_as_unsigned(mem_as_unsigned),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read with byte extension, addresses wrap at LIM.
    always_comb begin
        ra = mem_read_addr[4:0];
        rb = mem_arr[ra];
        if (mem_as_byte) begin
            mem_read_data = mem_as_unsigned ? {24'd0, rb} : {{24{rb[7]}}, rb};
        end else begin
            mem_read_data = {mem_arr[5'(ra + 5'd3)], mem_arr[5'(ra + 5'd2)],
                             mem_arr[5'(ra + 5'd1)], mem_arr[ra]};
        end
    end

    // Memory model: synchronous store.
    always @(posedge clk) begin
        if (mem_write_en) begin
            wa = mem_write_addr[4:0];
            mem_arr[wa] <= mem_write_data[7:0];
            if (!mem_as_byte) begin
                mem_arr[5'(wa + 5'd1)] <= mem_write_data[15:8];
                mem_arr[5'(wa + 5'd2)] <= mem_write_data[23:16];
                mem_arr[5'(wa + 5'd3)] <= mem_write_data[31:24];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void expect_ack(input logic port, input logic we, input logic err,
                                       input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e.port  = port;
        e.we    = we;
        e.err   = err;
        e.addr  = addr;
        e.rdata = rdata;
        sb.push_back(e);
    endfunction

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic sz_byte, input logic uns);
        if (port) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = wdata;
            b_as_byte = sz_byte; b_as_unsigned = uns;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = wdata;
            a_as_byte = sz_byte; a_as_unsigned = uns;
        end
    endtask

    // One complete access on one port; waits (bounded) for its ack then drops req.
    task automatic access(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic sz_byte, input logic uns,
                          input logic err, input logic [31:0] rdata);
        bit got;
        expect_ack(port, we, err, addr, rdata);
        @(negedge clk);
        drive_port(port, 1'b1, we, addr, wdata, sz_byte, uns);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (port ? b_ack : a_ack) got = 1;
        end
        if (!got) check_val("ack_timeout", 32'd0, 32'd1);
        if (port) b_req = 1'b0; else a_req = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard: every ack must match the oldest expected entry; stores only when legal.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_write_en) begin
                wr_ok = (sb.size() > 0) && sb[0].we && !sb[0].err && (mem_write_addr == sb[0].addr);
                check_val("wr_en_allowed", {31'd0, wr_ok}, 32'd1);
            end
            if (a_ack || b_ack) begin
                if (sb.size() == 0) begin
                    check_val("unexpected_ack", {30'd0, b_ack, a_ack}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("ack_port", {31'd0, b_ack}, {31'd0, mon_e.port});
                    check_val("ack_single", {31'd0, a_ack && b_ack}, 32'd0);
                    check_val("ack_err", {31'd0, mon_e.port ? b_err : a_err}, {31'd0, mon_e.err});
                    check_val("other_err", {31'd0, mon_e.port ? a_err : b_err}, 32'd0);
                    if (!mon_e.we) check_val("rdata", mon_e.port ? b_rdata : a_rdata, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        int cnt;
        bit got;
        rst_n = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive_port(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_a_ack", {31'd0, a_ack}, 32'd0);
        check_val("rst_b_ack", {31'd0, b_ack}, 32'd0);
        check_val("rst_a_err", {31'd0, a_err}, 32'd0);
        check_val("rst_b_err", {31'd0, b_err}, 32'd0);
        check_val("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
        check_val("rst_mem_raddr", mem_read_addr, 32'd0);
        check_val("rst_mem_waddr", mem_write_addr, 32'd0);
        check_val("rst_a_rdata", a_rdata, 32'd0);
        check_val("rst_b_rdata", b_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Scenario 1: word store then unsigned byte load of its top byte.
        access(1'b0, 1'b1, 32'd4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'd0);
        access(1'b0, 1'b0, 32'd7, 32'd0, 1'b1, 1'b1, 1'b0, 32'h000000DE);

        // Scenario 2: byte store 0x80, then signed and unsigned byte loads.
        access(1'b1, 1'b1, 32'd0, 32'h00000080, 1'b1, 1'b0, 1'b0, 32'd0);
        access(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'hFFFFFF80);
        access(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h00000080);

        // Scenario 4 and range boundaries.
        access(1'b0, 1'b1, 32'd29, 32'h55667788, 1'b0, 1'b0, 1'b1, 32'd0);
        access(1'b0, 1'b0, 32'd32, 32'd0, 1'b1, 1'b1, 1'b1, 32'd0);
        access(1'b0, 1'b1, 32'd28, 32'h11223344, 1'b0, 1'b0, 1'b0, 32'd0);
        access(1'b0, 1'b0, 32'd31, 32'd0, 1'b1, 1'b1, 1'b0, 32'h00000011);
        access(1'b1, 1'b0, 32'd28, 32'd0, 1'b0, 1'b0, 1'b0, 32'h11223344);
        access(1'b1, 1'b0, 32'd29, 32'd0, 1'b0, 1'b0, 1'b1, 32'd0);

        // Scenario 3: both ports held high across four grants.
        apply_reset();
`ifdef DMEM_ARB_FIXED_PRI_EN
        for (int i = 0; i < 4; i++) expect_ack(1'b0, 1'b0, 1'b0, 32'd4, 32'hDEADBEEF);
        expect_ack(1'b1, 1'b0, 1'b0, 32'd0, 32'h00000080);
`else
        for (int i = 0; i < 2; i++) begin
            expect_ack(1'b0, 1'b0, 1'b0, 32'd4, 32'hDEADBEEF);
            expect_ack(1'b1, 1'b0, 1'b0, 32'd0, 32'h00000080);
        end
`endif
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0);
        drive_port(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 4; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) cnt++;
        end
        a_req = 1'b0;
`ifndef DMEM_ARB_FIXED_PRI_EN
        b_req = 1'b0;
`endif
        if (cnt < 4) check_val("tie_timeout", 32'(cnt), 32'd4);
`ifdef DMEM_ARB_FIXED_PRI_EN
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (b_ack) got = 1;
        end
        b_req = 1'b0;
        if (!got) check_val("b_after_fixed_timeout", 32'd0, 32'd1);
`endif

        // Scenario 5: reset asserted while a store is in SERVE.
        repeat (2) @(negedge clk);
        expect_ack(1'b0, 1'b1, 1'b0, 32'd8, 32'd0);
        drive_port(1'b0, 1'b1, 1'b1, 32'd8, 32'hCAFEF00D, 1'b0, 1'b0);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (mem_write_en) got = 1;
        end
        if (!got) check_val("serve_timeout", 32'd0, 32'd1);
        a_req = 1'b0;
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check_val("abort_mem_we", {31'd0, mem_write_en}, 32'd0);
        check_val("abort_mem_waddr", mem_write_addr, 32'd0);
        check_val("abort_mem_wdata", mem_write_data, 32'd0);
        check_val("abort_a_ack", {31'd0, a_ack}, 32'd0);
        check_val("abort_a_rdata", a_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Fresh request after the abort: ack exactly two edges after it is sampled.
        expect_ack(1'b0, 1'b0, 1'b0, 32'd4, 32'hDEADBEEF);
        drive_port(1'b0, 1'b1, 1'b0, 32'd4, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_val("lat_serve_ack", {31'd0, a_ack}, 32'd0);
        @(posedge clk);
        #1 check_val("lat_done_ack", {31'd0, a_ack}, 32'd1);
        @(negedge clk);
        a_req = 1'b0;

        repeat (4) @(negedge clk);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
